// File: rtl/pixel_stream_packer_pkg.sv
// Purpose: shared types and constants for the pixel stream packer.
// Latency: n/a (types only).
// Backpressure: n/a. Provides pixel_t, pix_entry_t, AXIS_PAD and ENTRY_W.
package pixel_stream_packer_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // One FIFO slot: raster tags travel with the pixel they belong to.
  typedef struct packed {
    logic   eof;
    logic   sof;
    logic   eol;
    pixel_t pix;
  } pix_entry_t;

  localparam logic [7:0] AXIS_PAD = 8'h00;
  localparam int         ENTRY_W  = $bits(pix_entry_t);

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Purpose: AXI4-Stream video bus (tdata/tvalid/tready/tuser/tlast).
// Latency: n/a (wiring only).
// Backpressure: tready from slave to master; master holds the beat while tvalid && !tready.
interface pixel_stream_packer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/pixel_stream_packer_sync_fifo.sv
// Purpose: generic synchronous FIFO, first-word-fall-through head with registered valid.
// Latency: an entry pushed at edge N is presented (out_valid=1) after edge N+1.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high), push/push_data, pop, pop_data/out_valid (head), full, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       out_valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             vld_q;
  logic             do_pop;
  logic             do_push;

  assign full      = (count_q == CW'(DEPTH));
  assign do_pop    = pop && vld_q;
  assign do_push   = push && (!full || do_pop);
  assign pop_data  = mem[rd_ptr];
  assign out_valid = vld_q;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      // Head is valid only if some entry that existed before this edge survives it;
      // an entry written at this edge becomes visible one edge later.
      vld_q <= do_pop ? (count_q > CW'(1)) : (count_q != '0);
    end
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Purpose: tag raster-order RGB888 pixels with sof/eol/eof, buffer them and emit AXI4-Stream video.
// Latency: pixel sampled at edge N is on m_axis after edge N+1; 1 pixel/cycle sustained.
// Backpressure: none upstream; stall_out warns early, pixels arriving at a full buffer are dropped (sticky overflow).
// Ports: clk, rst (sync active-high), valid_in/pixel_in, m_axis (master), stall_out, overflow, ovf_clr,
//        frame_done; drop_count (16-bit saturating) only when PIXEL_PACKER_OVF_CNT_EN is defined.
module pixel_stream_packer
  import pixel_stream_packer_pkg::*;
#(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int FIFO_DEPTH   = 16,
  parameter int STALL_MARGIN = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  pixel_t               pixel_in,
  pixel_stream_packer_if.master m_axis,
  output logic                 stall_out,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic                 frame_done
`ifdef PIXEL_PACKER_OVF_CNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] STALL_THR = CW'(FIFO_DEPTH - STALL_MARGIN);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          x_last;
  logic          y_last;
  pix_entry_t    wr_entry;
  pix_entry_t    head;
  logic          fifo_vld;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          pop;
  logic          drop;

  assign x_last = (x_q == XW'(IMG_WIDTH - 1));
  assign y_last = (y_q == YW'(IMG_HEIGHT - 1));

  assign wr_entry.eof = x_last && y_last;
  assign wr_entry.sof = (x_q == '0) && (y_q == '0);
  assign wr_entry.eol = x_last;
  assign wr_entry.pix = pixel_in;

  // Counters follow every strobe, accepted or not, so tags stay raster-aligned after a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (valid_in) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign pop  = fifo_vld && m_axis.tready;
  assign drop = valid_in && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (valid_in),
    .push_data (wr_entry),
    .pop       (pop),
    .pop_data  (head),
    .out_valid (fifo_vld),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Beat fields are gated so the bus reads all-zero whenever nothing is presented.
  assign m_axis.tvalid = fifo_vld;
  assign m_axis.tdata  = fifo_vld ? {AXIS_PAD, head.pix} : '0;
  assign m_axis.tuser  = fifo_vld && head.sof;
  assign m_axis.tlast  = fifo_vld && head.eol;

  assign stall_out = (fifo_count > STALL_THR);

  // A drop in the same cycle as ovf_clr wins, so no loss is ever silently cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && head.eof;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef PIXEL_PACKER_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop) begin
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (ovf_clr) begin
      drop_count <= '0;
    end
  end
`endif

endmodule

// File: doc/pixel_stream_packer.md
# pixel_stream_packer

Downstream neighbour of the shading stage. Accepts one 24-bit RGB888 pixel per `valid_in` in raster order and tags it with start-of-frame and end-of-line markers from internal x/y counters. Buffers pixels in a small FIFO and emits them as a 32-bit AXI4-Stream video stream towards the VDMA. Raises `stall_out` so the ray issuer can pause before the buffer overflows, because the shading pipeline has no backpressure.

## Interface
Parameters:
- IMG_WIDTH, 640, pixels per line (≥2)
- IMG_HEIGHT, 480, lines per frame (≥1)
- FIFO_DEPTH, 16, buffer entries; power of two, ≥4
- STALL_MARGIN, 6, free entries below which `stall_out` asserts; covers upstream in-flight pixels

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  pixel strobe from shading
- pixel_in  in  24  {R[7:0],G[7:0],B[7:0]}
- m_axis_tdata  out  32  {8'h00, R, G, B}
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  sink ready
- m_axis_tuser  out  1  first pixel of frame
- m_axis_tlast  out  1  last pixel of line
- stall_out  out  1  free entries < STALL_MARGIN
- overflow  out  1  sticky: pixel dropped since reset or `ovf_clr`
- ovf_clr  in  1  clears `overflow` (and counter, see Configuration)
- frame_done  out  1  one-cycle pulse when last pixel of frame is transferred

## Operation
- Input counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) advance on every `valid_in`, including dropped pixels, to keep raster alignment.
- Tags computed at input: sof = (x==0 && y==0), eol = (x==IMG_WIDTH-1), eof = eol && (y==IMG_HEIGHT-1). FIFO entry = {eof, sof, eol, pixel} (27 bits).
- x wraps to 0 at IMG_WIDTH-1 and increments y. y wraps to 0 at end of frame.
- Write accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise the pixel is dropped and `overflow` sets the following cycle.
- Pop when m_axis_tvalid && m_axis_tready. `tdata`, `tuser`, `tlast` remain stable while tvalid && !tready.
- `frame_done` pulses the cycle after popping an entry with eof=1.
- `ovf_clr` and a drop in the same cycle: the drop wins, so `overflow` stays 1.
- `stall_out` is combinational from the registered count: (FIFO_DEPTH − count) < STALL_MARGIN.

## Timing
- Reset: all outputs 0; x=y=0; FIFO empty; `stall_out`=0 (requires STALL_MARGIN ≤ FIFO_DEPTH).
- Latency: a pixel written into an empty FIFO at edge N appears with tvalid=1 after edge N+1. Output register is first-word-fall-through.
- Throughput: 1 pixel/cycle sustained when tready=1.
- Reset mid-frame: FIFO flushed, counters zeroed. The next `valid_in` is tagged sof.
- Empty FIFO with tready=1: tvalid=0 and no pop.
- Full FIFO with pop and `valid_in` in the same cycle: accepted, count unchanged.

## Configuration
- `PIXEL_PACKER_OVF_CNT_EN` defined:
  - Adds output port `drop_count` (16 bits), a saturating count of dropped pixels.
  - Holds at 16'hFFFF once reached.
  - Cleared by `ovf_clr` in the same way as `overflow`.
  - Reset value 0.
- `PIXEL_PACKER_OVF_CNT_EN` undefined: port and counter are absent. Only the sticky `overflow` flag exists.

## Structure
- Shared package:
  - `pixel_t` typedef (24-bit packed struct r,g,b)
  - `pix_entry_t` typedef {eof,sof,eol,pixel_t}
  - `AXIS_PAD` constant 8'h00
- Sub-module `sync_fifo`:
  - Parameterised width/depth
  - Synchronous active-high reset
  - Registered count
  - Simultaneous push/pop when full is allowed
  - First-word-fall-through output
- Top level contains the counters, tagging, overflow logic and AXIS mapping.

## Test plan
- Reset then one pixel 24'h123456 with tready=1 → one cycle later tdata=32'h00123456, tvalid=1, tuser=1, tlast=0; nothing else in flight.
- Parameters IMG_WIDTH=4, IMG_HEIGHT=2: stream 8 pixels, tready=1 → tlast on beats 3 and 7, tuser on beat 0 only, `frame_done` pulse after beat 7. Ninth pixel carries tuser=1 (wrap).
- tready=0, FIFO_DEPTH=16, STALL_MARGIN=6: push 16 pixels → `stall_out`=1 after the 11th, no drop. The 17th pixel sets `overflow`, and `drop_count`=1 when the macro is enabled.
- FIFO full, tready=1 and valid_in in the same cycle → no drop, count stays 16, output order preserved.
- Backpressure toggling tready every cycle over 20 pixels → sink receives all 20 pixels in order; tdata stable while stalled.
- Reset asserted mid-line (x=2) with 5 entries buffered → tvalid=0 next cycle. The next pixel after reset is emitted with tuser=1.
